// File: rtl/display_turn_ctrl.sv
// Display refresh scanner and two-player turn sequencer (placement, then alternating fire turns).
// Optional fire-turn timeout is built when macro FIRE_TIMEOUT_EN is defined.
module display_turn_ctrl #(
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter int unsigned SHIPS          = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       turn_done,
    input  logic       game_over,
    output logic [2:0] refreshcounter,
    output logic [7:0] anode,
    output logic       p1place,
    output logic       p2place,
    output logic       p1fire,
    output logic       p2fire,
    output logic [3:0] ships_left
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned SW = 4;
    localparam int unsigned TW = 32;

    // Elaboration-time parameter sanity checks
    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("REFRESH_DIV must be at least 2");
    end
    if (SHIPS < 1 || SHIPS > 15) begin : g_bad_ships
        $error("SHIPS must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        P1_PLACE = 3'd1,
        P2_PLACE = 3'd2,
        P1_FIRE  = 3'd3,
        P2_FIRE  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] ships_next;
    logic          p1place_next;
    logic          p2place_next;
    logic          p1fire_next;
    logic          p2fire_next;

    logic [PW-1:0] presc;
    logic          presc_wrap;
    logic          turn_done_q;
    logic          turn_edge;
    logic          timeout_hit;

    assign presc_wrap = (presc == PW'(REFRESH_DIV - 1));
    assign turn_edge  = turn_done & ~turn_done_q;

    // Digit scan: prescaler, digit index and one-cold anode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc          <= '0;
            refreshcounter <= 3'd0;
            anode          <= 8'b1111_1110;
        end else if (presc_wrap) begin
            presc          <= '0;
            refreshcounter <= refreshcounter + 3'd1;
            anode          <= ~(8'd1 << (refreshcounter + 3'd1));
        end else begin
            presc <= presc + PW'(1);
        end
    end

`ifdef FIRE_TIMEOUT_EN
    logic [TW-1:0] tmo_cnt;

    // Fire-turn cycle counter, restarted on every state change or confirm edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state_next != state || turn_edge) begin
            tmo_cnt <= '0;
        end else if (state == P1_FIRE || state == P2_FIRE) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign timeout_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register; flags and ship count are registered alongside it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            turn_done_q <= 1'b0;
            ships_left  <= '0;
            p1place     <= 1'b0;
            p2place     <= 1'b0;
            p1fire      <= 1'b0;
            p2fire      <= 1'b0;
        end else begin
            state       <= state_next;
            turn_done_q <= turn_done;
            ships_left  <= ships_next;
            p1place     <= p1place_next;
            p2place     <= p2place_next;
            p1fire      <= p1fire_next;
            p2fire      <= p2fire_next;
        end
    end

    // Next-state and ship-count logic; game_over outranks a turn pass
    always_comb begin
        state_next = state;
        ships_next = ships_left;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = P1_PLACE;
                    ships_next = SW'(SHIPS);
                end
            end
            P1_PLACE: begin
                if (turn_edge) begin
                    if (ships_left == SW'(1)) begin
                        state_next = P2_PLACE;
                        ships_next = SW'(SHIPS);
                    end else begin
                        ships_next = ships_left - SW'(1);
                    end
                end
            end
            P2_PLACE: begin
                if (turn_edge) begin
                    if (ships_left == SW'(1)) begin
                        state_next = P1_FIRE;
                        ships_next = '0;
                    end else begin
                        ships_next = ships_left - SW'(1);
                    end
                end
            end
            P1_FIRE: begin
                ships_next = '0;
                if (game_over) begin
                    state_next = IDLE;
                end else if (turn_edge || timeout_hit) begin
                    state_next = P2_FIRE;
                end
            end
            P2_FIRE: begin
                ships_next = '0;
                if (game_over) begin
                    state_next = IDLE;
                end else if (turn_edge || timeout_hit) begin
                    state_next = P1_FIRE;
                end
            end
            default: begin
                state_next = IDLE;
                ships_next = '0;
            end
        endcase
    end

    // Phase flag decode of the upcoming state
    always_comb begin
        p1place_next = 1'b0;
        p2place_next = 1'b0;
        p1fire_next  = 1'b0;
        p2fire_next  = 1'b0;
        unique case (state_next)
            P1_PLACE: p1place_next = 1'b1;
            P2_PLACE: p2place_next = 1'b1;
            P1_FIRE:  p1fire_next  = 1'b1;
            P2_FIRE:  p2fire_next  = 1'b1;
            default:  ;
        endcase
    end

endmodule
